// File: rtl/data_memory_ws.sv
// Wait-stated, byte-addressed data memory for the MEM stage.
// Maps a window starting at BASE_ADDR onto DEPTH_BYTES of byte storage.
// Supports per-lane write enables and big- or little-endian lane order.
// The response is delayed by a programmable number of wait cycles.
//
// Handshake: a request (mem_r_en/mem_w_en) is accepted on the first rising
// edge where busy=0. The requester holds the request until then. busy stays
// high for the whole access, and requests seen while busy=1 are dropped.
// ready pulses for exactly one cycle when the access completes. result and
// addr_err are valid in that same cycle.
module data_memory_ws #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic [31:0]             address,
    input  logic [DATA_WIDTH-1:0]   dataToWrite,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    busy,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    addr_err,
    output logic [1:0]              state_dbg
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;

    // Request captured at accept; later input changes cannot disturb it.
    logic [31:0]           lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [NB-1:0]         lat_be;
    logic                  lat_wr;

    logic [7:0] mem [DEPTH_BYTES];

    logic [31:0]           word_addr;
    logic [31:0]           offset;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  accept;
    logic                  finish;

    // Requests are only taken in IDLE. finish marks the RESP-entry edge,
    // where writes commit and read data is captured.
    assign accept = (state == S_IDLE) && (mem_r_en || mem_w_en);
    assign finish = (state == S_WAIT) && (cnt == 4'd0);

    // Word-align the latched address and locate it inside the window.
    assign word_addr = lat_addr & ~32'(NB - 1);
    assign offset    = word_addr - 32'(BASE_ADDR);
    assign in_range  = (word_addr >= 32'(BASE_ADDR)) && (offset < 32'(DEPTH_BYTES));
    assign idx       = offset[IDX_W-1:0];
    assign state_dbg = state;

    // Assemble the addressed word. Byte offset+k lands in lane NB-1-k when
    // BIG_ENDIAN=1, and in lane k when BIG_ENDIAN=0.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NB; k++) begin
            rd_word[8*(BIG_ENDIAN != 0 ? NB-1-k : k) +: 8] = mem[idx + IDX_W'(k)];
        end
    end

    // Next state. WAIT is entered with the counter at WAIT_CYCLES and left
    // one cycle after the counter reaches zero. RESP is therefore entered
    // WAIT_CYCLES+1 edges after accept, including when WAIT_CYCLES=0.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b1;
        ready    = 1'b0;
        addr_err = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nx = S_WAIT;
                    cnt_nx   = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nx = S_RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            S_RESP: begin
                ready    = 1'b1;
                addr_err = !in_range;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, counter, request capture and result register. An async reset
    // forces IDLE, so a pending write never reaches its commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            result   <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            lat_wr   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_addr <= address;
                lat_data <= dataToWrite;
                lat_be   <= byte_en;
                lat_wr   <= mem_w_en;     // both enables high counts as a write
            end
            if (finish && !lat_wr) begin
                result <= in_range ? rd_word : '0;
            end
        end
    end

    // Storage is not reset. Only enabled lanes of an in-range write change.
    always_ff @(posedge clk) begin
        if (finish && lat_wr && in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (lat_be[BIG_ENDIAN != 0 ? NB-1-k : k]) begin
                    mem[idx + IDX_W'(k)] <= lat_data[8*(BIG_ENDIAN != 0 ? NB-1-k : k) +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws. It runs three instances in lockstep on
// shared inputs:
//   m: big-endian, 2 wait cycles
//   l: little-endian, 2 wait cycles
//   z: big-endian, 0 wait cycles
module tb_data_memory_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address;
    logic [31:0] data_w;
    logic [3:0]  byte_en;

    logic        m_busy, m_ready, m_err;
    logic [31:0] m_result;
    logic [1:0]  m_state;
    logic        l_busy, l_ready, l_err;
    logic [31:0] l_result;
    logic [1:0]  l_state;
    logic        z_busy, z_ready, z_err;
    logic [31:0] z_result;
    logic [1:0]  z_state;

    int n_cmp = 0;
    int n_bad = 0;
    int lat, zlat;
    logic err;

    // Clock generation.
    always #5 clk = ~clk;

    data_memory_ws #(.WAIT_CYCLES(2), .BIG_ENDIAN(1)) dut_m (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .dataToWrite(data_w), .byte_en(byte_en),
        .busy(m_busy), .ready(m_ready), .result(m_result), .addr_err(m_err),
        .state_dbg(m_state));

    data_memory_ws #(.WAIT_CYCLES(2), .BIG_ENDIAN(0)) dut_l (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .dataToWrite(data_w), .byte_en(byte_en),
        .busy(l_busy), .ready(l_ready), .result(l_result), .addr_err(l_err),
        .state_dbg(l_state));

    data_memory_ws #(.WAIT_CYCLES(0), .BIG_ENDIAN(1)) dut_z (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .dataToWrite(data_w), .byte_en(byte_en),
        .busy(z_busy), .ready(z_ready), .result(z_result), .addr_err(z_err),
        .state_dbg(z_state));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle. Returns 1 time unit after the accept edge.
    task automatic issue(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        mem_r_en = r;
        mem_w_en = w;
        address  = a;
        data_w   = d;
        byte_en  = be;
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    // Count edges until m signals ready. Also note the edge where z first
    // shows ready. Then check that ready drops and m is idle on the next edge.
    task automatic wait_resp(output int l_out, output int z_out, output logic e_out);
        l_out = 0;
        z_out = 0;
        e_out = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (z_ready && z_out == 0) z_out = i;
            if (m_ready) begin
                l_out = i;
                e_out = m_err;
                break;
            end
        end
        if (l_out == 0) chk("resp_timeout", m_ready, 1);
        @(posedge clk);
        #1;
        chk("ready_fall", m_ready, 0);
        chk("idle_after", m_busy, 0);
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address = '0;
        data_w = '0;
        byte_en = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", m_busy, 0);
        chk("rst_ready", m_ready, 0);
        chk("rst_err", m_err, 0);
        chk("rst_result", m_result, 0);
        chk("rst_state", m_state, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Preload two words used later.
        issue(0, 1, 32'd1276, 32'h01020304, 4'hF); wait_resp(lat, zlat, err);
        issue(0, 1, 32'd1032, 32'hCAFEF00D, 4'hF); wait_resp(lat, zlat, err);

        // Word write and read-back, with latency checks.
        issue(0, 1, 32'd1024, 32'h11223344, 4'hF);
        chk("accept_busy", m_busy, 1);
        wait_resp(lat, zlat, err);
        chk("wr_latency", lat, 3);
        chk("z_latency", zlat, 1);
        chk("wr_err", err, 0);
        chk("be_byte0", dut_m.mem[0], 8'h11);
        chk("be_byte3", dut_m.mem[3], 8'h44);
        chk("le_byte0", dut_l.mem[0], 8'h44);
        chk("le_byte3", dut_l.mem[3], 8'h11);
        issue(1, 0, 32'd1024, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("rd_latency", lat, 3);
        chk("rd_z_latency", zlat, 1);
        chk("rd_m", m_result, 32'h11223344);
        chk("rd_l", l_result, 32'h11223344);
        chk("rd_z", z_result, 32'h11223344);

        // Partial write: only lanes 0 and 2 change.
        issue(0, 1, 32'd1024, 32'hAABBCCDD, 4'b0101);
        wait_resp(lat, zlat, err);
        chk("wr_keeps_result", m_result, 32'h11223344);
        issue(1, 0, 32'd1024, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("bytes_m", m_result, 32'h11BB33DD);
        chk("bytes_l", l_result, 32'h11BB33DD);

        // Range checks.
        issue(1, 0, 32'd1280, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("hi_err", err, 1);
        chk("hi_latency", lat, 3);
        chk("hi_result", m_result, 0);
        issue(1, 0, 32'd1024, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("inr_err", err, 0);
        chk("inr_result", m_result, 32'h11BB33DD);
        issue(1, 0, 32'd1020, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("lo_err", err, 1);
        chk("lo_result", m_result, 0);
        issue(0, 1, 32'd1020, 32'hFFFFFFFF, 4'hF);
        wait_resp(lat, zlat, err);
        chk("lo_wr_err", err, 1);
        issue(1, 0, 32'd1024, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("lo_wr_word0", m_result, 32'h11BB33DD);
        issue(1, 0, 32'd1276, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("lo_wr_last", m_result, 32'h01020304);
        chk("last_err", err, 0);

        // A request pulsed while busy is dropped.
        issue(1, 0, 32'd1024, 32'h0, 4'h0);
        mem_r_en = 1'b1;
        address  = 32'd1026;
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        wait_resp(lat, zlat, err);
        chk("busy_rd_latency", lat, 2);
        chk("busy_rd_result", m_result, 32'h11BB33DD);
        @(posedge clk);
        #1;
        chk("busy_ignored", m_busy, 0);

        // Both enables high is a write. Low address bits are dropped.
        issue(1, 1, 32'd1028, 32'h5, 4'hF);
        wait_resp(lat, zlat, err);
        chk("both_keeps_result", m_result, 32'h11BB33DD);
        issue(1, 0, 32'd1030, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("both_readback", m_result, 32'h00000005);

        // Reset one cycle into a write. The zero-wait instance has already
        // committed by then.
        issue(0, 1, 32'd1032, 32'hDEADBEEF, 4'hF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", m_busy, 0);
        chk("mid_rst_ready", m_ready, 0);
        chk("mid_rst_state", m_state, 0);
        chk("mid_rst_z_ready", z_ready, 0);
        chk("mid_rst_result", m_result, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(1, 0, 32'd1032, 32'h0, 4'h0);
        wait_resp(lat, zlat, err);
        chk("mid_rst_m", m_result, 32'hCAFEF00D);
        chk("mid_rst_l", l_result, 32'hCAFEF00D);
        chk("mid_rst_z", z_result, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
